alu_sequencer: RTL and testbench

//   Front-end controller for the 4-bit board ALU. Turns two board push-buttons and
//   the operand switches into a complete operation sequence:

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - button-driven load/select/execute/hold sequencer for the board ALU
module alu_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next_n,
  input  logic             btn_op_n,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             result_valid,
  output logic [2:0]       state,
  output logic [3:0]       op_idx
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES);
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_SEL_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  // index 0 = next button, index 1 = op button
  logic [1:0]         w_raw;
  logic [1:0]         r_sync0, r_sync1, r_db, r_press;
  logic [1:0][DW-1:0] r_cnt;

  assign w_raw = {btn_op_n, btn_next_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
      r_db    <= 2'b11;
      r_press <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync1[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]    <= r_sync1[i];
          r_cnt[i]   <= '0;
          r_press[i] <= ~r_sync1[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_a_nxt, w_b_nxt, w_result_nxt;
  logic [3:0]       r_op_idx, r_flags, w_op_nxt, w_flags_nxt;
  logic             r_valid, w_valid_nxt;
  logic [STW-1:0]   r_settle, w_settle_nxt;
  logic             w_next, w_op;

  assign w_next = r_press[0];
  assign w_op   = r_press[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOAD_A;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_op_idx <= 4'd0;
      r_flags  <= 4'd0;
      r_valid  <= 1'b0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_result <= w_result_nxt;
      r_op_idx <= w_op_nxt;
      r_flags  <= w_flags_nxt;
      r_valid  <= w_valid_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_result_nxt = r_result;
    w_op_nxt     = r_op_idx;
    w_flags_nxt  = r_flags;
    w_valid_nxt  = r_valid;
    w_settle_nxt = r_settle;
    case (r_state)
      S_LOAD_A: if (w_next) begin
        w_a_nxt     = sw;
        w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: if (w_next) begin
        w_b_nxt     = sw;
        w_state_nxt = S_SEL_OP;
      end
      S_SEL_OP: begin
        // next takes priority over a coincident op press
        if (w_next) begin
          w_settle_nxt = '0;
          w_state_nxt  = S_EXEC;
        end else if (w_op) begin
          w_op_nxt = (r_op_idx == 4'd9) ? 4'd0 : r_op_idx + 4'd1;
        end
      end
      S_EXEC: begin
        if (r_settle == STW'(SETTLE_CYCLES - 1)) begin
          w_result_nxt = alu_s;
          w_flags_nxt  = {alu_cout, alu_z, alu_n, alu_v};
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_HOLD;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      S_HOLD: if (w_next) begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_LOAD_A;
      end
      default: w_state_nxt = S_LOAD_A;
    endcase
  end

  // active-low op-select is simply the complement of op_idx+1 (0 -> 1110 ... 9 -> 0101)
  assign alu_sel      = (r_state == S_EXEC || r_state == S_HOLD) ? ~(r_op_idx + 4'd1) : 4'b1111;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign result       = r_result;
  assign flags        = r_flags;
  assign result_valid = r_valid;
  assign state        = r_state;
  assign op_idx       = r_op_idx;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed table-driven bench for alu_sequencer with a board ALU model
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next_n, btn_op_n;
  logic [3:0] alu_s;
  logic       alu_cout, alu_z, alu_n, alu_v;
  logic [3:0] alu_a, alu_b, alu_sel, result, flags, op_idx;
  logic       result_valid;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int n_trans = 0;
  logic [2:0] r_prev = 3'd0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next_n(btn_next_n), .btn_op_n(btn_op_n),
    .alu_s(alu_s), .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .result(result), .flags(flags),
    .result_valid(result_valid), .state(state), .op_idx(op_idx)
  );

  // board ALU: unsigned, N only on subtract borrow, V on mul overflow / divide by zero
  logic [4:0] t;
  logic [7:0] p;
  always_comb begin
    t = 5'd0; p = 8'd0;
    alu_s = 4'd0; alu_cout = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
    case (alu_sel)
      4'b1110: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_s = t[3:0]; alu_cout = t[4]; end
      4'b1101: begin
        t = {1'b0, alu_a} - {1'b0, alu_b}; alu_s = t[3:0]; alu_cout = t[4]; alu_n = (alu_a < alu_b);
      end
      4'b1100: begin p = {4'd0, alu_a} * {4'd0, alu_b}; alu_s = p[3:0]; alu_v = (p > 8'd15); end
      4'b1011: if (alu_b == 4'd0) begin alu_s = 4'hF; alu_v = 1'b1; end else alu_s = alu_a / alu_b;
      4'b1010: if (alu_b == 4'd0) begin alu_s = 4'hF; alu_v = 1'b1; end else alu_s = alu_a % alu_b;
      4'b1001: alu_s = alu_a & alu_b;
      4'b1000: alu_s = alu_a | alu_b;
      4'b0111: alu_s = alu_a ^ alu_b;
      4'b0110: begin alu_s = {alu_a[2:0], 1'b0}; alu_cout = alu_a[3]; end
      4'b0101: begin alu_s = {1'b0, alu_a[3:1]}; alu_cout = alu_a[0]; end
      default: alu_s = 4'd0;
    endcase
    alu_z = (alu_s == 4'd0);
  end

  always @(negedge clk) begin
    if (r_prev == 3'd0 && state == 3'd1) n_trans <= n_trans + 1;
    r_prev <= state;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input bit nxt, input bit op);
    if (nxt) btn_next_n = 1'b0;
    if (op)  btn_op_n   = 1'b0;
    repeat (10) @(negedge clk);
    btn_next_n = 1'b1;
    btn_op_n   = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] a, b, op, exp_sel, exp_res, exp_flags;
  } vec_t;
  vec_t vecs[7];

  int cur_op;
  int npress;
  int base;
  bit found;

  initial begin
    vecs[0] = '{4'd5,  4'd3,  4'd0, 4'b1110, 4'd8,  4'b0000};
    vecs[1] = '{4'd6,  4'd3,  4'd2, 4'b1100, 4'd2,  4'b0001};
    vecs[2] = '{4'd9,  4'd0,  4'd3, 4'b1011, 4'hF,  4'b0001};
    vecs[3] = '{4'd2,  4'd7,  4'd1, 4'b1101, 4'hB,  4'b1010};
    vecs[4] = '{4'd12, 4'd10, 4'd5, 4'b1001, 4'd8,  4'b0000};
    vecs[5] = '{4'd7,  4'd7,  4'd7, 4'b0111, 4'd0,  4'b0100};
    vecs[6] = '{4'd9,  4'd4,  4'd8, 4'b0110, 4'd2,  4'b1000};

    rst = 1'b1; sw = 4'd0; btn_next_n = 1'b1; btn_op_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_sel", alu_sel, 4'b1111);
    check("rst_valid", result_valid, 0);
    check("rst_regs", {alu_a, alu_b, result, flags, op_idx}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // bouncy press: only the stable tail may count
    sw = 4'd5;
    base = n_trans;
    for (int i = 0; i < 10; i++) begin
      btn_next_n = i[0];
      @(negedge clk);
    end
    btn_next_n = 1'b0;
    repeat (20) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_presses", n_trans - base, 1);
    check("bounce_state", state, 1);
    check("bounce_a", alu_a, 5);

    do_reset();
    cur_op = 0;
    for (int v = 0; v < 7; v++) begin
      sw = vecs[v].a; press(1, 0);
      sw = vecs[v].b; press(1, 0);
      check("vec_selop_state", state, 2);
      npress = (int'(vecs[v].op) - cur_op + 10) % 10;
      for (int k = 0; k < npress; k++) press(0, 1);
      cur_op = vecs[v].op;
      check("vec_op_idx", op_idx, vecs[v].op);
      btn_next_n = 1'b0;
      for (int k = 0; k < 30 && !result_valid; k++) @(negedge clk);
      check("vec_valid", result_valid, 1);
      btn_next_n = 1'b1;
      repeat (10) @(negedge clk);
      check("vec_state_hold", state, 4);
      check("vec_sel", alu_sel, vecs[v].exp_sel);
      check("vec_result", result, vecs[v].exp_res);
      check("vec_flags", flags, vecs[v].exp_flags);
      press(0, 1);
      check("hold_op_ignored", op_idx, vecs[v].op);
      press(1, 0);
      check("ret_state", state, 0);
      check("ret_valid", result_valid, 0);
      check("ret_sel", alu_sel, 4'b1111);
      check("ret_a_kept", alu_a, vecs[v].a);
      check("ret_b_kept", alu_b, vecs[v].b);
    end

    // ten op presses wrap back, then a simultaneous op+next must not advance op_idx
    press(0, 1);
    check("op_ignored_load_a", op_idx, cur_op);
    sw = 4'd1; press(1, 0);
    sw = 4'd2; press(1, 0);
    for (int k = 0; k < 10; k++) press(0, 1);
    check("wrap_op_idx", op_idx, cur_op);
    press(1, 1);
    check("simul_state", state, 4);
    check("simul_op_idx", op_idx, cur_op);
    check("simul_result", result, 2);
    press(1, 0);
    check("simul_ret", state, 0);

    // reset one cycle after entering EXEC
    sw = 4'd3; press(1, 0);
    sw = 4'd4; press(1, 0);
    btn_next_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (state == 3'd3) found = 1'b1;
    end
    check("exec_reached", found, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_sel", alu_sel, 4'b1111);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_regs", {alu_a, alu_b, result, flags, op_idx}, 0);
    btn_next_n = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_state", state, 0);
    check("post_rst_no_capture", {result_valid, result}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
